// File: rtl/serial_register_tx.sv
// Parallel-in, serial-out transmitter.
// Takes a WIDTH-bit word over a valid/ready handshake and shifts it out
// MSB-first on sdata. sclk and the frame strobe are generated alongside, and
// done pulses once after the last bit. Every output is registered.
module serial_register_tx #(
  parameter int WIDTH      = 8,  // bits per frame, 2..32
  parameter int BIT_CYCLES = 4   // clk cycles per serial bit, even and >= 2
) (
  input  logic             clk,
  input  logic             reset,      // synchronous, active-low
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             frame,
  output logic             done
);

  localparam int CYC_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_HALF = CYC_W'(BIT_CYCLES / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CYC_W-1:0] cyc_q,   cyc_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  logic             load_ready_d, sclk_d, sdata_d, frame_d, done_d;

  logic [CYC_W-1:0] cyc_inc;
  assign cyc_inc = cyc_q + 1'b1;

  // State, datapath and output registers; a low reset overrides everything,
  // including a handshake on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cyc_q      <= '0;
      bit_q      <= '0;
      load_ready <= 1'b1;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      frame      <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      load_ready <= load_ready_d;
      sclk       <= sclk_d;
      sdata      <= sdata_d;
      frame      <= frame_d;
      done       <= done_d;
    end
  end

  // Next-state logic; output values are computed one cycle ahead so the
  // registered outputs line up with the counters they describe.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    load_ready_d = load_ready;
    sclk_d       = sclk;
    sdata_d      = sdata;
    frame_d      = frame;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        load_ready_d = 1'b1;
        if (load_valid) begin
          state_d      = SHIFT;
          shift_d      = data;
          cyc_d        = '0;
          bit_d        = '0;
          load_ready_d = 1'b0;
          frame_d      = 1'b1;
          sclk_d       = 1'b0;
          sdata_d      = data[WIDTH-1];
        end
      end

      SHIFT: begin
        load_ready_d = 1'b0;
        if (cyc_q == CYC_LAST) begin
          if (bit_q == BIT_LAST) begin
            // Last cycle of the last bit: close the frame.
            state_d = DONE;
            cyc_d   = '0;
            bit_d   = '0;
            frame_d = 1'b0;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Bit boundary: sclk is about to go low, so sdata may change.
            cyc_d   = '0;
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            sdata_d = shift_q[WIDTH-2];
            sclk_d  = 1'b0;
          end
        end else begin
          cyc_d  = cyc_inc;
          sclk_d = (cyc_inc >= CYC_HALF);
        end
      end

      DONE: begin
        state_d      = IDLE;
        load_ready_d = 1'b1;
        frame_d      = 1'b0;
        sclk_d       = 1'b0;
        sdata_d      = 1'b0;
      end

      default: begin
        state_d      = IDLE;
        load_ready_d = 1'b1;
        frame_d      = 1'b0;
        sclk_d       = 1'b0;
        sdata_d      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_register_tx.sv
// Self-checking bench for serial_register_tx (WIDTH=8, BIT_CYCLES=4).
// Expected waveforms come from a cycle-indexed model of the frame: in frame
// cycle k the bit on the line is k/BIT_CYCLES and sclk is high in the second
// half of each bit. A separate monitor records sdata at every sclk rise.
module tb_serial_register_tx;

  localparam int W  = 8;
  localparam int BC = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data = '0;
  logic         load_valid = 1'b0;
  logic         load_ready, sclk, sdata, frame, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit stream_q[$];

  serial_register_tx #(.WIDTH(W), .BIT_CYCLES(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .sclk       (sclk),
    .sdata      (sdata),
    .frame      (frame),
    .done       (done)
  );

  always #5 clk = ~clk;

  // What a downstream receiver would see: sdata at every sclk rise in a frame.
  always @(posedge sclk) if (frame === 1'b1) stream_q.push_back(sdata);

  // Count done pulses.
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Output bundle {load_ready, frame, sclk, sdata, done}.
  function automatic logic [4:0] outs();
    return {load_ready, frame, sclk, sdata, done};
  endfunction

  // Reference: outputs in frame cycle k while transmitting word.
  function automatic logic [4:0] model_frame(input logic [W-1:0] word, input int k);
    int b;
    b = k / BC;
    return {1'b0, 1'b1, ((k % BC) >= BC / 2), word[W-1-b], 1'b0};
  endfunction

  // Called at an IDLE negedge: present word, let it be accepted, drop valid.
  // Returns at the negedge of the first frame cycle.
  task automatic send(input logic [W-1:0] word, input bit scramble);
    data = word;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    if (scramble) data = ~word;
  endtask

  // Called at the negedge of frame cycle 0; checks the whole frame, the done
  // cycle and the following IDLE cycle, then the captured serial stream.
  // Returns at the IDLE-cycle negedge.
  task automatic check_frame(input logic [W-1:0] word, input string tag);
    logic [4:0] exp_v;
    logic [W-1:0] got;
    stream_q.delete();
    for (int k = 0; k < W * BC; k++) begin
      exp_v = model_frame(word, k);
      checks++;
      if (outs() !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: outs=%b expected=%b", tag, k, outs(), exp_v);
      end
      @(negedge clk);
    end
    checks++;
    if (outs() !== 5'b00001) begin
      errors++;
      $display("FAIL %s done cycle: outs=%b expected=00001", tag, outs());
    end
    @(negedge clk);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL %s idle after done: outs=%b expected=10000", tag, outs());
    end
    got = '0;
    foreach (stream_q[i]) if (i < W) got[W-1-i] = stream_q[i];
    checks++;
    if (stream_q.size() != W || got !== word) begin
      errors++;
      $display("FAIL %s stream: got %0d bits value %h expected %0d bits value %h",
               tag, stream_q.size(), got, W, word);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    load_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset held: outs=%b expected=10000", outs());
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset released: outs=%b expected=10000", outs());
    end
  endtask

  task automatic test_basic();
    int d0;
    d0 = done_cnt;
    send(8'hA5, 1'b0);
    check_frame(8'hA5, "basic_a5");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL basic done count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_data_change();
    send(8'h3C, 1'b0);
    data = 8'hFF;
    check_frame(8'h3C, "data_change");
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    data = 8'h81;
    load_valid = 1'b1;
    @(negedge clk);
    data = 8'h7E;                 // queued; ignored until IDLE
    check_frame(8'h81, "b2b_first");
    // load_valid still high at the IDLE cycle: accepted on the next edge.
    @(negedge clk);
    load_valid = 1'b0;
    check_frame(8'h7E, "b2b_second");
    checks++;
    if (done_cnt - d0 != 2) begin
      errors++;
      $display("FAIL b2b done count: got %0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    send(8'hA5, 1'b0);
    repeat (4 * BC + 1) @(negedge clk);   // inside bit 4
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL midframe precondition: frame=%b expected=1", frame);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL midframe abort: outs=%b expected=10000", outs());
    end
    reset = 1'b1;
    for (int i = 0; i < W * BC; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 5'b10000) begin
        errors++;
        $display("FAIL after abort cycle %0d: outs=%b expected=10000", i, outs());
      end
    end
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort done count: got %0d expected 0", done_cnt - d0);
    end
    send(8'h5A, 1'b0);
    check_frame(8'h5A, "after_abort_5a");
  endtask

  task automatic test_reset_with_valid();
    reset = 1'b0;
    data = 8'hFF;
    load_valid = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    load_valid = 1'b0;
    checks++;
    if (outs() !== 5'b10000) begin
      errors++;
      $display("FAIL reset+valid: outs=%b expected=10000", outs());
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (outs() !== 5'b10000) begin
        errors++;
        $display("FAIL reset+valid idle: outs=%b expected=10000", outs());
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] word;
    int gap;
    for (int n = 0; n < 8; n++) begin
      word = W'($urandom);
      gap  = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        checks++;
        if (outs() !== 5'b10000) begin
          errors++;
          $display("FAIL random gap %0d: outs=%b expected=10000", n, outs());
        end
      end
      send(word, 1'($urandom_range(0, 1)));
      check_frame(word, $sformatf("random_%0d", n));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_data_change();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_with_valid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
